config_shift_chain: RTL and testbench

- Parametrised configuration shift chain for a logic or IO tile.
- Serial (or LANES-wide) configuration data is shifted into a staging register.
- Completed loads are transferred to a separate active register on an explicit commit, so tile configuration never glitches while shifting.
- Bits shifted out of the top are forwarded on chain_out, so tiles daisy-chain into one bitstream.

---
 rtl/config_shift_chain_if.sv | 33 +++
 rtl/config_shift_chain.sv | 90 +++++++++
 tb/tb_config_shift_chain.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/config_shift_chain_if.sv
// Configuration shift chain bus.
// Groups the shift/commit controls and the tile-facing outputs of config_shift_chain.
//   master : drives enable, data_in, clear and commit; observes the outputs
//   slave  : the chain itself; drives data_out, chain_out, word_count, full,
//            config_valid and commit_error
interface config_shift_chain_if #(
  parameter int unsigned CONFIG_WIDTH = 524,
  parameter int unsigned LANES        = 1
);
  localparam int unsigned WORDS = CONFIG_WIDTH / LANES;
  localparam int unsigned CW    = $clog2(WORDS + 1);

  logic                    enable;
  logic [LANES-1:0]        data_in;
  logic                    clear;
  logic                    commit;
  logic [CONFIG_WIDTH-1:0] data_out;
  logic [LANES-1:0]        chain_out;
  logic [CW-1:0]           word_count;
  logic                    full;
  logic                    config_valid;
  logic                    commit_error;

  modport master (
    output enable, data_in, clear, commit,
    input  data_out, chain_out, word_count, full, config_valid, commit_error
  );

  modport slave (
    input  enable, data_in, clear, commit,
    output data_out, chain_out, word_count, full, config_valid, commit_error
  );
endinterface

// File: rtl/config_shift_chain.sv
// Configuration shift chain for a logic/IO tile.
// LANES-wide words shift into a staging register; an accepted commit copies the
// full staging register into the active register that drives the tile, so the
// tile never sees a half-shifted configuration. The top word of staging is
// forwarded on chain_out for daisy-chaining tiles.
// Ports:
//   clock  : rising-edge clock
//   nreset : asynchronous active-low reset
//   bus    : config_shift_chain_if slave (enable, data_in, clear, commit in;
//            data_out, chain_out, word_count, full, config_valid, commit_error out)
module config_shift_chain #(
  parameter int unsigned CONFIG_WIDTH = 524,
  parameter int unsigned LANES        = 1
) (
  input logic                clock,
  input logic                nreset,
  config_shift_chain_if.slave bus
);
  localparam int unsigned WORDS = CONFIG_WIDTH / LANES;
  localparam int unsigned CW    = $clog2(WORDS + 1);

  logic [CONFIG_WIDTH-1:0] staging_q, staging_d;
  logic [CONFIG_WIDTH-1:0] active_q, active_d;
  logic [CW-1:0]           count_q, count_d;
  logic                    valid_q, valid_d;
  logic                    err_q, err_d;

  logic                    full_w;
  logic                    commit_ok;
  // Concatenate then truncate so the shift stays legal when LANES == CONFIG_WIDTH.
  logic [CONFIG_WIDTH+LANES-1:0] shift_w;

  assign full_w    = (count_q == CW'(WORDS));
  assign commit_ok = bus.commit && full_w;
  assign shift_w   = {staging_q, bus.data_in};

  always_comb begin
    staging_d = staging_q;
    active_d  = active_q;
    count_d   = count_q;
    valid_d   = valid_q;
    err_d     = 1'b0;

    // Commit sees pre-edge state, so it captures staging before any shift/clear.
    if (bus.commit) begin
      if (full_w) begin
        active_d = staging_q;
        valid_d  = 1'b1;
        count_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end

    if (bus.clear) begin
      staging_d = '0;
      count_d   = '0;
    end else if (bus.enable) begin
      staging_d = shift_w[CONFIG_WIDTH-1:0];
      if (commit_ok) begin
        count_d = CW'(1);
      end else if (!full_w) begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      staging_q <= '0;
      active_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      staging_q <= staging_d;
      active_q  <= active_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.data_out     = active_q;
  assign bus.chain_out    = staging_q[CONFIG_WIDTH-1 -: LANES];
  assign bus.word_count   = count_q;
  assign bus.full         = full_w;
  assign bus.config_valid = valid_q;
  assign bus.commit_error = err_q;
endmodule

// File: tb/tb_config_shift_chain.sv
// Bench for config_shift_chain: an 8x2 build driven from a vector table through a
// scoreboard queue, plus a default 524x1 build loaded with an LFSR bitstream.
module tb_config_shift_chain;
  logic clock;
  logic nreset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  config_shift_chain_if #(.CONFIG_WIDTH(8), .LANES(2)) sbus ();
  config_shift_chain_if bbus ();

  config_shift_chain #(.CONFIG_WIDTH(8), .LANES(2)) dut_small (
    .clock  (clock),
    .nreset (nreset),
    .bus    (sbus)
  );

  config_shift_chain dut_big (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bbus)
  );

  typedef struct {
    logic       en;
    logic [1:0] din;
    logic       clr;
    logic       cmt;
    logic [7:0] dout;
    logic [1:0] chain;
    logic [2:0] wc;
    logic       fl;
    logic       valid;
    logic       err;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  logic [523:0] big_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic step(input vec_t v, input int idx);
    vec_t e;
    sbus.enable  = v.en;
    sbus.data_in = v.din;
    sbus.clear   = v.clr;
    sbus.commit  = v.cmt;
    sb_q.push_back(v);
    @(posedge clock);
    #1;
    e = sb_q.pop_front();
    chk($sformatf("v%0d data_out", idx), 32'(sbus.data_out), 32'(e.dout));
    chk($sformatf("v%0d chain_out", idx), 32'(sbus.chain_out), 32'(e.chain));
    chk($sformatf("v%0d word_count", idx), 32'(sbus.word_count), 32'(e.wc));
    chk($sformatf("v%0d full", idx), 32'(sbus.full), 32'(e.fl));
    chk($sformatf("v%0d config_valid", idx), 32'(sbus.config_valid), 32'(e.valid));
    chk($sformatf("v%0d commit_error", idx), 32'(sbus.commit_error), 32'(e.err));
  endtask

  initial begin
    logic [15:0]  lfsr;
    logic [523:0] pat;
    logic [523:0] exp_big;

    nreset = 1'b0;
    sbus.enable = 1'b0; sbus.data_in = '0; sbus.clear = 1'b0; sbus.commit = 1'b0;
    bbus.enable = 1'b0; bbus.data_in = '0; bbus.clear = 1'b0; bbus.commit = 1'b0;

    //          en din clr cmt dout   chain wc fl vl er
    tbl.push_back('{1, 2'd3, 0, 0, 8'h00, 2'd0, 3'd1, 0, 0, 0}); // full load
    tbl.push_back('{1, 2'd2, 0, 0, 8'h00, 2'd0, 3'd2, 0, 0, 0});
    tbl.push_back('{1, 2'd1, 0, 0, 8'h00, 2'd0, 3'd3, 0, 0, 0});
    tbl.push_back('{1, 2'd0, 0, 0, 8'h00, 2'd3, 3'd4, 1, 0, 0}); // staging E4
    tbl.push_back('{1, 2'd0, 0, 0, 8'h00, 2'd2, 3'd4, 1, 0, 0}); // overflow -> 90
    tbl.push_back('{0, 2'd0, 0, 1, 8'h90, 2'd2, 3'd0, 0, 1, 0}); // commit
    tbl.push_back('{1, 2'd1, 0, 0, 8'h90, 2'd1, 3'd1, 0, 1, 0}); // early commit
    tbl.push_back('{1, 2'd2, 0, 0, 8'h90, 2'd0, 3'd2, 0, 1, 0});
    tbl.push_back('{1, 2'd3, 0, 0, 8'h90, 2'd0, 3'd3, 0, 1, 0});
    tbl.push_back('{0, 2'd0, 0, 1, 8'h90, 2'd0, 3'd3, 0, 1, 1}); // refused
    tbl.push_back('{0, 2'd0, 0, 0, 8'h90, 2'd0, 3'd3, 0, 1, 0}); // pulse ends
    tbl.push_back('{0, 2'd0, 1, 0, 8'h90, 2'd0, 3'd0, 0, 1, 0}); // clear while filling
    tbl.push_back('{1, 2'd3, 1, 0, 8'h90, 2'd0, 3'd0, 0, 1, 0}); // clear beats enable
    tbl.push_back('{1, 2'd3, 0, 0, 8'h90, 2'd0, 3'd1, 0, 1, 0}); // reload E4
    tbl.push_back('{1, 2'd2, 0, 0, 8'h90, 2'd0, 3'd2, 0, 1, 0});
    tbl.push_back('{1, 2'd1, 0, 0, 8'h90, 2'd0, 3'd3, 0, 1, 0});
    tbl.push_back('{1, 2'd0, 0, 0, 8'h90, 2'd3, 3'd4, 1, 1, 0});
    tbl.push_back('{1, 2'd1, 0, 1, 8'hE4, 2'd2, 3'd1, 0, 1, 0}); // enable+commit, staging 91
    tbl.push_back('{1, 2'd2, 0, 0, 8'hE4, 2'd1, 3'd2, 0, 1, 0}); // staging 46
    tbl.push_back('{1, 2'd3, 0, 0, 8'hE4, 2'd0, 3'd3, 0, 1, 0}); // staging 1B
    tbl.push_back('{1, 2'd0, 0, 0, 8'hE4, 2'd1, 3'd4, 1, 1, 0}); // staging 6C
    tbl.push_back('{1, 2'd3, 1, 1, 8'h6C, 2'd0, 3'd0, 0, 1, 0}); // clear+commit+enable
    tbl.push_back('{0, 2'd0, 0, 1, 8'h6C, 2'd0, 3'd0, 0, 1, 1}); // commit when empty
    tbl.push_back('{0, 2'd0, 0, 0, 8'h6C, 2'd0, 3'd0, 0, 1, 0});

    #12;
    chk("reset data_out", 32'(sbus.data_out), 32'h0);
    chk("reset chain_out", 32'(sbus.chain_out), 32'h0);
    chk("reset word_count", 32'(sbus.word_count), 32'h0);
    chk("reset full", 32'(sbus.full), 32'h0);
    chk("reset config_valid", 32'(sbus.config_valid), 32'h0);
    chk("reset commit_error", 32'(sbus.commit_error), 32'h0);
    #1 nreset = 1'b1;
    @(posedge clock);
    #1;

    foreach (tbl[i]) step(tbl[i], i);

    // Mid-cycle asynchronous reset with a committed config and nonzero count.
    sbus.enable = 1'b1; sbus.data_in = 2'd3; sbus.clear = 1'b0; sbus.commit = 1'b0;
    @(posedge clock);
    #1;
    sbus.enable = 1'b0;
    chk("pre-reset word_count", 32'(sbus.word_count), 32'h1);
    #2 nreset = 1'b0;
    #1;
    chk("async reset data_out", 32'(sbus.data_out), 32'h0);
    chk("async reset word_count", 32'(sbus.word_count), 32'h0);
    chk("async reset config_valid", 32'(sbus.config_valid), 32'h0);
    chk("async reset chain_out", 32'(sbus.chain_out), 32'h0);
    chk("async reset full", 32'(sbus.full), 32'h0);
    #3 nreset = 1'b1;

    // Default 524x1 build: LFSR bitstream, first bit ends up at the top.
    @(posedge clock);
    #1;
    lfsr = 16'hACE1;
    pat  = '0;
    for (int i = 0; i < 524; i++) begin
      bbus.enable  = 1'b1;
      bbus.data_in = lfsr[0];
      pat[523-i]   = lfsr[0];
      lfsr = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      @(posedge clock);
      #1;
    end
    bbus.enable = 1'b0;
    chk("big word_count", 32'(bbus.word_count), 32'd524);
    chk("big full", 32'(bbus.full), 32'h1);
    chk("big config_valid before commit", 32'(bbus.config_valid), 32'h0);
    bbus.commit = 1'b1;
    big_q.push_back(pat);
    @(posedge clock);
    #1;
    bbus.commit = 1'b0;
    exp_big = big_q.pop_front();
    checks++;
    if (bbus.data_out !== exp_big) begin
      errors++;
      $display("FAIL big data_out: got %0h expected %0h", bbus.data_out[63:0], exp_big[63:0]);
    end
    chk("big config_valid", 32'(bbus.config_valid), 32'h1);
    chk("big word_count after commit", 32'(bbus.word_count), 32'h0);
    chk("big commit_error", 32'(bbus.commit_error), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
